// File: rtl/parout_monitor.sv
// Parallel-out checker: captures CPU output words into a FIFO, compares them in order
// against a reference stream and registers a pass/fail verdict after a drain window.
module parout_monitor #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned DRAIN_CYCLES = 5,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              Clk_CI,
   input  logic              Rst_RI,
   input  logic [DATA_W-1:0] ParO_DI,
   input  logic              ParO_valid_SI,
   input  logic              EoC_SI,
   input  logic [DATA_W-1:0] Ref_DI,
   input  logic              Ref_valid_SI,
   input  logic              Ref_last_SI,
   output logic              Ref_ready_SO,
   output logic              Done_SO,
   output logic              Pass_SO,
   output logic              Overflow_SO,
   output logic [CNT_W-1:0]  ByteCnt_DO,
   output logic [CNT_W-1:0]  MismatchCnt_DO,
   output logic [CNT_W-1:0]  FirstErrIdx_DO
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned DC_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [AW:0]      FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]      FIFO_ONE   = (AW + 1)'(1);
   localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
   localparam logic [DC_W-1:0]  DRAIN_LOAD = DC_W'(DRAIN_CYCLES);
   localparam logic [DC_W-1:0]  DRAIN_ONE  = DC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [DC_W-1:0]     drain_q, drain_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                ref_done_q, ref_done_d;
   logic                err_seen_q, err_seen_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [CNT_W-1:0]    byte_q, byte_d;
   logic [CNT_W-1:0]    mism_q, mism_d;
   logic [CNT_W-1:0]    first_q, first_d;

   logic capture_s, pop_s, push_s, drop_s, full_s, mism_s;

   // Handshake: pop only while a word is buffered and the reference stream is still open.
   always_comb begin
      full_s    = (cnt_q == FIFO_FULL);
      capture_s = ParO_valid_SI && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
      pop_s     = (cnt_q != '0) && Ref_valid_SI && !ref_done_q && (state_q != ST_DONE);
      push_s    = capture_s && (!full_s || pop_s);
      drop_s    = capture_s && full_s && !pop_s;
      mism_s    = pop_s && (mem_q[rd_ptr_q] != Ref_DI);
   end

   assign Ref_ready_SO = pop_s;

   // Phase sequencing; the drain counter reaching zero after its last decrement ends DRAIN.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         ST_RUN: begin
            if (EoC_SI) begin
               if (DRAIN_LOAD == '0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - DRAIN_ONE;
            if (drain_q <= DRAIN_ONE) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_CHECK: state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_RUN;
      endcase
   end

   // FIFO bookkeeping, compare counters and verdict.
   always_comb begin
      wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + FIFO_ONE;
         2'b01:   cnt_d = cnt_q - FIFO_ONE;
         default: cnt_d = cnt_q;
      endcase
      ovf_d      = ovf_q || drop_s;
      ref_done_d = ref_done_q || (pop_s && Ref_last_SI);
      byte_d     = pop_s ? (byte_q + CNT_ONE) : byte_q;
      if (mism_s && (mism_q != '1)) begin
         mism_d = mism_q + CNT_ONE;
      end else begin
         mism_d = mism_q;
      end
      if (mism_s && !err_seen_q) begin
         first_d    = byte_q;
         err_seen_d = 1'b1;
      end else begin
         first_d    = first_q;
         err_seen_d = err_seen_q;
      end
      if (state_q == ST_CHECK) begin
         done_d = 1'b1;
         pass_d = (mism_q == '0) && !ovf_q && (cnt_q == '0) && ref_done_q;
      end else begin
         done_d = done_q;
         pass_d = pass_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_q    <= ST_RUN;
         drain_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         ref_done_q <= 1'b0;
         err_seen_q <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         byte_q     <= '0;
         mism_q     <= '0;
         first_q    <= '1;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         ref_done_q <= ref_done_d;
         err_seen_q <= err_seen_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         byte_q     <= byte_d;
         mism_q     <= mism_d;
         first_q    <= first_d;
      end
   end

   // Capture storage; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge Clk_CI) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= ParO_DI;
      end
   end

   assign Done_SO        = done_q;
   assign Pass_SO        = pass_q;
   assign Overflow_SO    = ovf_q;
   assign ByteCnt_DO     = byte_q;
   assign MismatchCnt_DO = mism_q;
   assign FirstErrIdx_DO = first_q;

endmodule

// File: doc/parout_monitor.md
Name: parout_monitor

Overview:
- Synthesizable parallel-output checker: captures bytes the CPU writes to its parallel-out port and compares them in order against an expected-data stream.
- Reports pass/fail once end-of-computation is seen and a programmable drain window has elapsed.
- Sits beside the Ibex SoC top so self-checking runs on FPGA/emulation as well as in simulation.
- Generalises data width, buffer depth, drain time and counter width; adds mismatch counting, first-error index, overflow, extra-data and missing-data detection.

Parameters:
- DATA_W, 8: width of the parallel-out word and of the reference word.
- FIFO_DEPTH, 16: capture buffer entries. Must be a power of two, >=2.
- DRAIN_CYCLES, 5: cycles after the EoC rising edge during which capture continues.
- CNT_W, 16: width of the byte, mismatch and index counters.

Ports:
- Clk_CI  in  1  clock, all logic on the rising edge.
- Rst_RI  in  1  synchronous active-high reset.
- ParO_DI  in  DATA_W  captured data from the CPU.
- ParO_valid_SI  in  1  data qualifier, one word per high cycle.
- EoC_SI  in  1  end-of-computation level from the CPU.
- Ref_DI  in  DATA_W  expected word.
- Ref_valid_SI  in  1  expected word available.
- Ref_last_SI  in  1  marks the final expected word; qualified by Ref_valid_SI.
- Ref_ready_SO  out  1  expected word consumed this cycle.
- Done_SO  out  1  verdict valid; sticky.
- Pass_SO  out  1  verdict; meaningful only when Done_SO=1.
- Overflow_SO  out  1  sticky: a capture was dropped.
- ByteCnt_DO  out  CNT_W  words compared so far.
- MismatchCnt_DO  out  CNT_W  mismatching compares.
- FirstErrIdx_DO  out  CNT_W  ByteCnt value at the first mismatch.

Behaviour:
- Reset (synchronous, Rst_RI=1 at a clock edge):
  - FIFO emptied, state=RUN.
  - All outputs 0. FirstErrIdx_DO = all ones (no error).
  - Internal flags err_seen and ref_done cleared.
  - Reset asserted in any state, including DRAIN or DONE, aborts and restarts cleanly.
- States: RUN, DRAIN, CHECK, DONE.
  - RUN -> DRAIN on the first cycle with EoC_SI=1; a drain counter is loaded with DRAIN_CYCLES.
  - DRAIN decrements each cycle -> CHECK when the counter is 0. DRAIN_CYCLES=0 goes straight to CHECK on the next cycle.
  - CHECK lasts one cycle -> DONE.
  - DONE is absorbing until reset.
  - EoC_SI is ignored outside RUN.
- Capture:
  - In RUN and DRAIN, ParO_valid_SI=1 pushes ParO_DI.
  - Push while full with no pop in the same cycle: word dropped, Overflow_SO=1 (sticky).
  - Push and pop in the same cycle while full: legal, no overflow.
  - Captures in CHECK or DONE are ignored.
- Compare:
  - Ref_ready_SO = FIFO non-empty AND Ref_valid_SI AND NOT ref_done AND state!=DONE. Combinational; this is the pop condition.
  - On pop, compare the FIFO head with Ref_DI. Results register one cycle later.
  - ByteCnt_DO increments on every pop.
  - On mismatch, MismatchCnt_DO increments; it saturates at all ones.
  - On the first mismatch, FirstErrIdx_DO = pre-increment ByteCnt.
  - Pop with Ref_last_SI=1 sets ref_done. No further pops after that.
  - The FIFO has zero bubble: a word pushed in cycle N may pop in cycle N+1.
- Verdict, evaluated in CHECK and registered on entry to DONE:
  - Pass_SO = (MismatchCnt=0) AND NOT Overflow AND FIFO empty AND ref_done.
  - FIFO non-empty at CHECK = extra output, fail.
  - ref_done=0 at CHECK = missing output, fail.
  - Done_SO rises in the same cycle as Pass_SO is valid.
- Counter widths: ByteCnt wraps modulo 2^CNT_W. Only MismatchCnt saturates.

Test Plan:
- Match: push 0x48,0x69,0x0A one per cycle; ref = same with last on 0x0A; EoC 2 cycles later -> Done_SO=1 at EoC+DRAIN_CYCLES+2, Pass_SO=1, ByteCnt=3, MismatchCnt=0, FirstErrIdx=0xFFFF.
- Mismatch: ref 0x41,0x42,0x43(last), DUT pushes 0x41,0x58,0x43 -> MismatchCnt=1, FirstErrIdx=1, Pass_SO=0.
- Overflow/backpressure: Ref_valid_SI=0, push 17 words with FIFO_DEPTH=16 -> Overflow_SO=1 on the 17th cycle. Repeat with one pop in the 17th cycle -> no overflow.
- Extra/missing: ref ends (last) after 2 words, DUT pushes 3 -> FIFO holds 1 at CHECK, Pass_SO=0. DUT pushes 2 but ref last is on word 3 -> ref_done=0, Pass_SO=0.
- Late push in drain: word pushed DRAIN_CYCLES-1 cycles after EoC is compared and counted. A push in DONE leaves ByteCnt unchanged.
- Reset mid-DRAIN: Rst_RI=1 for one cycle -> next cycle all outputs 0, FirstErrIdx=0xFFFF, state RUN, a fresh matching run passes.
